// File: rtl/bcd_display_scan.sv
// Multiplexed 7-segment scanner for cascaded BCD counters: per-frame digit
// snapshot, dead time at the start of every slot, optional leading-zero blanking.
module bcd_display_scan #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLKS_PER_DIGIT = 12000,
   parameter int BLANK_CLKS     = 16,
   parameter int LZ_BLANK       = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                    sys_clk,
   input  logic                    sys_reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic                    frame_tick
);

   localparam int CW = $clog2(CLKS_PER_DIGIT);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic {BLANK, SHOW} state_t;

   state_t                       state, nxt_state;
   logic [IW-1:0]                idx, nxt_idx;
   logic [CW-1:0]                cnt, nxt_cnt;
   logic [NUM_DIGITS-1:0][3:0]   shadow, nxt_shadow;
   logic                         restart, load, zero_run, slot_end;
   logic [NUM_DIGITS-1:0]        blank, sel_hi;
   logic [6:0]                   seg_hi;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0: decode = 7'h3F;
         4'd1: decode = 7'h06;
         4'd2: decode = 7'h5B;
         4'd3: decode = 7'h4F;
         4'd4: decode = 7'h66;
         4'd5: decode = 7'h6D;
         4'd6: decode = 7'h7D;
         4'd7: decode = 7'h07;
         4'd8: decode = 7'h7F;
         4'd9: decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   // Outputs are computed from next-state values so the registered outputs
   // line up with the registered state in the same cycle.
   always_comb begin
      nxt_cnt   = cnt;
      nxt_idx   = idx;
      nxt_state = state;
      slot_end  = (cnt == CW'(CLKS_PER_DIGIT - 1));
      if (restart) begin
         nxt_cnt   = '0;
         nxt_idx   = '0;
         nxt_state = BLANK;
      end else if (slot_end) begin
         nxt_cnt   = '0;
         nxt_idx   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         nxt_state = BLANK;
      end else begin
         nxt_cnt = cnt + 1'b1;
         if (state == BLANK && nxt_cnt == CW'(BLANK_CLKS))
            nxt_state = SHOW;
      end

      load       = (nxt_idx == '0) && (nxt_cnt == '0) && (nxt_state == BLANK);
      nxt_shadow = load ? digits : shadow;

      // Walk from the top digit down; a digit is blank while everything above is zero.
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (nxt_shadow[i] == 4'd0);
         blank[i] = (LZ_BLANK != 0) && (i != 0) && zero_run;
      end

      seg_hi = '0;
      sel_hi = '0;
      if (nxt_state == SHOW && !blank[nxt_idx]) begin
         seg_hi          = decode(nxt_shadow[nxt_idx]);
         sel_hi[nxt_idx] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state      <= BLANK;
         idx        <= '0;
         cnt        <= '0;
         shadow     <= '0;
         restart    <= 1'b1;
         seg        <= (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
         sel        <= (SEL_ACTIVE_LOW != 0) ? '1 : '0;
         frame_tick <= 1'b0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cnt        <= nxt_cnt;
         shadow     <= nxt_shadow;
         restart    <= 1'b0;
         seg        <= (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
         sel        <= (SEL_ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
         frame_tick <= load;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: a cycle model pushes expected sel/seg/frame_tick at each
// edge, and the sample taken on the falling edge is popped and compared.
module tb_bcd_display_scan;
   localparam int ND  = 4;
   localparam int CPD = 8;
   localparam int BC  = 2;
   localparam int FR  = ND * CPD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits = 16'h1234;
   logic [6:0]  seg;
   logic [3:0]  sel;
   logic        frame_tick;

   always #5 clk = ~clk;

   bcd_display_scan #(
      .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BC),
      .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
   ) dut (
      .sys_clk(clk), .sys_reset(rst), .digits(digits),
      .seg(seg), .sel(sel), .frame_tick(frame_tick)
   );

   typedef struct packed {
      logic [3:0] sel;
      logic [6:0] seg;
      logic       tick;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          t = 0;
   logic [15:0] snap = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s cycle=%0d got %h want %h", tag, t, got, want);
      end
   endtask

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
         4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
         4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // t is the cycle number (since reset release) of the cycle following this edge.
   task automatic model();
      exp_t e;
      int   idx, c;
      logic lz;
      e.sel  = 4'hF;
      e.seg  = 7'h7F;
      e.tick = 1'b0;
      if (rst) begin
         t = 0;
      end else begin
         idx    = (t / CPD) % ND;
         c      = t % CPD;
         e.tick = (t % FR == 0);
         if (e.tick) snap = digits;
         lz = 1'b1;
         for (int i = ND - 1; i >= idx; i--)
            lz = lz && (snap[4*i +: 4] == 4'd0);
         if (c >= BC && !(idx != 0 && lz)) begin
            e.sel = ~(4'b0001 << idx);
            e.seg = ~dec(snap[4*idx +: 4]);
         end
         t++;
      end
      sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      exp_t e;
      repeat (n) begin
         @(posedge clk);
         model();
         @(negedge clk);
         e = sb.pop_front();
         chk("sel", 32'(sel), 32'(e.sel));
         chk("seg", 32'(seg), 32'(e.seg));
         chk("frame_tick", 32'(frame_tick), 32'(e.tick));
      end
   endtask

   initial begin
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(FR);
      digits = 16'h0050; cyc(FR);
      digits = 16'h0000; cyc(FR);
      digits = 16'h00A0; cyc(FR);
      digits = 16'h1234; cyc(12);
      digits = 16'h9876; cyc(FR - 12);
      cyc(FR);
      digits = 16'h1234; cyc(22);
      rst = 1'b1; cyc(2);
      rst = 1'b0; cyc(FR + 2);
      repeat (6) begin
         digits = 16'($urandom) >> (4 * $urandom_range(0, 3));
         cyc(FR);
      end
      digits = 16'hFFF0; cyc(2 * FR);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
